// File: rtl/cpu_sequencer_if.sv
// Fetch and ALU bundle between the 4-bit CPU sequencer and its neighbours.
// The master side is the sequencer; the slave side is memory plus the ALU.
interface cpu_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_req;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic [3:0]        alu_op;
    logic [3:0]        alu_rx;
    logic [3:0]        alu_ry;
    logic [3:0]        alu_out;
    logic              alu_z;
    logic              alu_n;

    modport master (
        output mem_addr, mem_req,
        output alu_op, alu_rx, alu_ry,
        input  mem_ack, mem_rdata,
        input  alu_out, alu_z, alu_n
    );

    modport slave (
        input  mem_addr, mem_req,
        input  alu_op, alu_rx, alu_ry,
        output mem_ack, mem_rdata,
        output alu_out, alu_z, alu_n
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Control unit for the 4-bit CPU: fetch, decode, ALU issue, writeback.
// Owns the PC, instruction register, 4x4 register file and Z/N flags.
module cpu_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    cpu_sequencer_if.master  bus,
    output logic             flag_z,
    output logic             flag_n,
    output logic             halted,
    input  logic [1:0]       dbg_sel,
    output logic [3:0]       dbg_data
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_FETCH2,
        S_HALT
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        ir;
    logic [3:0]        regs [4];
    logic [3:0]        alu_op_q;
    logic [3:0]        alu_rx_q;
    logic [3:0]        alu_ry_q;

    logic [3:0] opc;
    logic [1:0] rx_i;
    logic [1:0] ry_i;
    logic       is_alu;
    logic       is_ldi;
    logic       is_jz;
    logic       is_jn;
    logic       is_two;
    logic       is_halt;

    assign opc     = ir[7:4];
    assign rx_i    = ir[3:2];
    assign ry_i    = ir[1:0];
    assign is_alu  = (opc >= 4'd1) && (opc <= 4'd8);
    assign is_ldi  = (opc == 4'd9);
    assign is_jz   = (opc == 4'd10);
    assign is_jn   = (opc == 4'd11);
    assign is_two  = is_ldi || is_jz || is_jn;
    assign is_halt = (opc == 4'd15);

    // Request is a pure decode of state so reset drops it immediately.
    assign bus.mem_req  = (state == S_FETCH) || (state == S_FETCH2);
    assign bus.mem_addr = pc;
    assign bus.alu_op   = alu_op_q;
    assign bus.alu_rx   = alu_rx_q;
    assign bus.alu_ry   = alu_ry_q;
    assign halted       = (state == S_HALT);
    assign dbg_data     = regs[dbg_sel];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_BOOT;
        else        state <= nxt;
    end

    // Next-state decode; fetch states hold until the memory acks.
    always_comb begin
        nxt = state;
        unique case (state)
            S_BOOT:   nxt = S_FETCH;
            S_FETCH:  if (bus.mem_ack) nxt = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    is_alu:  nxt = S_EXEC;
                    is_two:  nxt = S_FETCH2;
                    is_halt: nxt = S_HALT;
                    default: nxt = S_FETCH;
                endcase
            end
            S_EXEC:   nxt = S_WB;
            S_WB:     nxt = S_FETCH;
            S_FETCH2: if (bus.mem_ack) nxt = S_FETCH;
            S_HALT:   nxt = S_HALT;
            default:  nxt = S_BOOT;
        endcase
    end

    // Datapath: PC/IR on fetch acks, ALU issue, writeback, operand use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            ir       <= '0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            alu_op_q <= '0;
            alu_rx_q <= '0;
            alu_ry_q <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (bus.mem_ack) begin
                        ir <= bus.mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    if (is_alu) begin
                        alu_op_q <= opc;
                        alu_rx_q <= regs[rx_i];
                        alu_ry_q <= regs[ry_i];
                    end
                end
                S_WB: begin
                    regs[rx_i] <= bus.alu_out;
                    flag_z     <= bus.alu_z;
                    flag_n     <= bus.alu_n;
                end
                S_FETCH2: begin
                    if (bus.mem_ack) begin
                        if ((is_jz && flag_z) || (is_jn && flag_n))
                            pc <= ADDR_W'(bus.mem_rdata);
                        else
                            pc <= pc + ADDR_W'(1);
                        if (is_ldi) regs[rx_i] <= bus.mem_rdata[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: memory responder with wait states, registered
// ALU stand-in, and an instruction-level reference interpreter.
`timescale 1ns/1ps
module tb_cpu_sequencer;

    localparam int ADDR_W = 8;
    localparam int LIMIT  = 3000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flag_z;
    logic       flag_n;
    logic       halted;
    logic [1:0] dbg_sel = 2'd0;
    logic [3:0] dbg_data;

    int checks = 0;
    int failures = 0;

    cpu_sequencer_if #(.ADDR_W(ADDR_W)) bus();

    cpu_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .halted   (halted),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // ALU stand-in: registered result, flags derived from it.
    function automatic logic [3:0] alu_f(input logic [3:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
        case (op)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a + 4'd1;
            4'd6: return ~a;
            4'd7: return a << 1;
            4'd8: return a >> 1;
            default: return 4'd0;
        endcase
    endfunction

    always @(posedge clk)
        bus.alu_out <= alu_f(bus.alu_op, bus.alu_rx, bus.alu_ry);
    assign bus.alu_z = (bus.alu_out == 4'd0);
    assign bus.alu_n = bus.alu_out[3];

    // Memory responder: acks after 'waits' idle cycles, logs each fetch.
    logic [7:0] mem [256];
    int         waits = 0;
    bit         spur = 1'b0;
    int         wcnt = 0;
    logic [7:0] dut_trace [$];

    always @(negedge clk) begin
        if (bus.mem_req) begin
            if (wcnt >= waits) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                dut_trace.push_back(bus.mem_addr);
                wcnt = 0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 8'($urandom);
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (spur) begin
                bus.mem_ack   = 1'($urandom);
                bus.mem_rdata = 8'($urandom);
            end else begin
                bus.mem_ack = 1'b0;
            end
        end
    end

    // Reference interpreter: executes the program byte by byte.
    logic [3:0] m_reg [4];
    logic       m_z;
    logic       m_n;
    logic [7:0] m_trace [$];
    int         m_cyc;
    bit         m_halt;

    task automatic model_run(input int w);
        logic [7:0] pc;
        logic [7:0] b;
        logic [7:0] o;
        logic [3:0] op;
        logic [3:0] r;
        int         x;
        int         y;
        pc = 8'd0;
        for (int i = 0; i < 4; i++) m_reg[i] = 4'd0;
        m_z = 1'b0;
        m_n = 1'b0;
        m_trace.delete();
        m_cyc = 1;
        m_halt = 1'b0;
        for (int s = 0; s < 600 && !m_halt; s++) begin
            b = mem[pc];
            m_trace.push_back(pc);
            pc = pc + 8'd1;
            op = b[7:4];
            x = int'(b[3:2]);
            y = int'(b[1:0]);
            if (op >= 4'd1 && op <= 4'd8) begin
                r = alu_f(op, m_reg[x], m_reg[y]);
                m_reg[x] = r;
                m_z = (r == 4'd0);
                m_n = r[3];
                m_cyc += w + 4;
            end else if (op >= 4'd9 && op <= 4'd11) begin
                o = mem[pc];
                m_trace.push_back(pc);
                pc = pc + 8'd1;
                if (op == 4'd9) m_reg[x] = o[3:0];
                if (op == 4'd10 && m_z) pc = o;
                if (op == 4'd11 && m_n) pc = o;
                m_cyc += 2 * w + 3;
            end else if (op == 4'd15) begin
                m_cyc += w + 2;
                m_halt = 1'b1;
            end else begin
                m_cyc += w + 2;
            end
        end
    endtask

    task automatic load_fill();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    // Resets, runs the loaded program to HALT and compares with the model.
    task automatic run_program(input int w, input bit sp, input string tag);
        int         cyc;
        bit         prev_req;
        logic [7:0] prev_addr;
        model_run(w);
        waits = w;
        spur = sp;
        rst_n = 1'b0;
        dut_trace.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        prev_req = 1'b0;
        prev_addr = 8'd0;
        while (!halted && cyc < LIMIT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (prev_req && !bus.mem_ack) begin
                checks++;
                if (bus.mem_req !== 1'b1 || bus.mem_addr !== prev_addr) begin
                    failures++;
                    $display("FAIL %s hold: req=%b addr=%h want req=1 addr=%h",
                             tag, bus.mem_req, bus.mem_addr, prev_addr);
                end
            end
            prev_req = bus.mem_req;
            prev_addr = bus.mem_addr;
        end
        checks++;
        if (cyc !== m_cyc) begin
            failures++;
            $display("FAIL %s cycles: got %0d want %0d", tag, cyc, m_cyc);
        end
        repeat (4) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.mem_req !== 1'b0 || halted !== 1'b1) begin
                failures++;
                $display("FAIL %s idle: req=%b halted=%b want 0/1",
                         tag, bus.mem_req, halted);
            end
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            checks++;
            if (dbg_data !== m_reg[i]) begin
                failures++;
                $display("FAIL %s reg%0d: got %h want %h",
                         tag, i, dbg_data, m_reg[i]);
            end
        end
        checks++;
        if (flag_z !== m_z || flag_n !== m_n) begin
            failures++;
            $display("FAIL %s flags: got z=%b n=%b want z=%b n=%b",
                     tag, flag_z, flag_n, m_z, m_n);
        end
        checks++;
        if (dut_trace != m_trace) begin
            failures++;
            $display("FAIL %s trace: got %p want %p", tag, dut_trace, m_trace);
        end
        spur = 1'b0;
    endtask

    logic [7:0] saved_trace [$];

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.mem_req !== 1'b0 || halted !== 1'b0 ||
            bus.mem_addr !== 8'd0) begin
            failures++;
            $display("FAIL reset_ctl: req=%b halted=%b addr=%h want 0/0/00",
                     bus.mem_req, halted, bus.mem_addr);
        end
        checks++;
        if (flag_z !== 1'b0 || flag_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: z=%b n=%b want 0/0", flag_z, flag_n);
        end
        checks++;
        if (bus.alu_op !== 4'd0 || bus.alu_rx !== 4'd0 ||
            bus.alu_ry !== 4'd0) begin
            failures++;
            $display("FAIL reset_alu: op=%h rx=%h ry=%h want 0/0/0",
                     bus.alu_op, bus.alu_rx, bus.alu_ry);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            checks++;
            if (dbg_data !== 4'd0) begin
                failures++;
                $display("FAIL reset_reg%0d: got %h want 0", i, dbg_data);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: req=%b want 0", bus.mem_req);
        end
    endtask

    task automatic test_program1();
        load_fill();
        mem[0] = 8'h94; mem[1] = 8'h03; mem[2] = 8'h15; mem[3] = 8'hF0;
        run_program(0, 1'b0, "prog1");
        saved_trace = dut_trace;
        dbg_sel = 2'd1;
        #1;
        checks++;
        if (dbg_data !== 4'd6 || flag_z !== 1'b0 || flag_n !== 1'b0) begin
            failures++;
            $display("FAIL prog1_result: r1=%h z=%b n=%b want 6/0/0",
                     dbg_data, flag_z, flag_n);
        end
    endtask

    task automatic test_wait_states();
        run_program(2, 1'b0, "wait2");
        checks++;
        if (dut_trace != saved_trace) begin
            failures++;
            $display("FAIL wait2_vs_zero: got %p want %p",
                     dut_trace, saved_trace);
        end
        dbg_sel = 2'd1;
        #1;
        checks++;
        if (dbg_data !== 4'd6) begin
            failures++;
            $display("FAIL wait2_r1: got %h want 6", dbg_data);
        end
    endtask

    task automatic test_jz();
        load_fill();
        mem[0] = 8'h90; mem[1] = 8'h05; mem[2] = 8'h94; mem[3] = 8'h05;
        mem[4] = 8'h21; mem[5] = 8'hA0; mem[6] = 8'h40;
        run_program(0, 1'b0, "jz_taken");
        checks++;
        if (flag_z !== 1'b1 || dut_trace[dut_trace.size()-1] !== 8'h40) begin
            failures++;
            $display("FAIL jz_taken: z=%b last=%h want 1/40",
                     flag_z, dut_trace[dut_trace.size()-1]);
        end
        mem[3] = 8'h04;
        run_program(1, 1'b1, "jz_not");
        checks++;
        if (flag_z !== 1'b0 || dut_trace[dut_trace.size()-1] !== 8'h07) begin
            failures++;
            $display("FAIL jz_not: z=%b last=%h want 0/07",
                     flag_z, dut_trace[dut_trace.size()-1]);
        end
    endtask

    task automatic test_ldi_inc_jn();
        load_fill();
        mem[0] = 8'h98; mem[1] = 8'h07; mem[2] = 8'h58;
        mem[3] = 8'hB0; mem[4] = 8'h10;
        run_program(0, 1'b1, "ldi_jn");
        dbg_sel = 2'd2;
        #1;
        checks++;
        if (dbg_data !== 4'h8 || flag_n !== 1'b1 ||
            dut_trace[dut_trace.size()-1] !== 8'h10) begin
            failures++;
            $display("FAIL ldi_jn: r2=%h n=%b last=%h want 8/1/10",
                     dbg_data, flag_n, dut_trace[dut_trace.size()-1]);
        end
    endtask

    task automatic test_pc_wrap();
        load_fill();
        mem[0] = 8'h9C; mem[1] = 8'hF5; mem[2] = 8'h6C;
        mem[3] = 8'hB0; mem[4] = 8'hFF; mem[255] = 8'h98;
        run_program(1, 1'b0, "wrap");
        dbg_sel = 2'd2;
        #1;
        checks++;
        if (dbg_data !== 4'hC || dut_trace.size() != 8) begin
            failures++;
            $display("FAIL wrap: r2=%h fetches=%0d want C/8",
                     dbg_data, dut_trace.size());
        end else begin
            checks++;
            if (dut_trace[5] !== 8'hFF || dut_trace[6] !== 8'h00 ||
                dut_trace[7] !== 8'h01) begin
                failures++;
                $display("FAIL wrap_addr: got %h %h %h want FF 00 01",
                         dut_trace[5], dut_trace[6], dut_trace[7]);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        int  n;
        bit  seen;
        load_fill();
        mem[0] = 8'h94; mem[1] = 8'h05; mem[2] = 8'h65;
        waits = 5;
        spur = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            seen = bus.mem_req && (bus.mem_addr == 8'd3);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midrst_reach: fetch of 03 not seen in %0d cycles", n);
        end
        dbg_sel = 2'd1;
        #1;
        checks++;
        if (dbg_data !== 4'hA || flag_n !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: r1=%h n=%b want A/1", dbg_data, flag_n);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL midrst_req: got %b want 0", bus.mem_req);
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            checks++;
            if (dbg_data !== 4'd0) begin
                failures++;
                $display("FAIL midrst_reg%0d: got %h want 0", i, dbg_data);
            end
        end
        checks++;
        if (flag_z !== 1'b0 || flag_n !== 1'b0) begin
            failures++;
            $display("FAIL midrst_flags: z=%b n=%b want 0/0", flag_z, flag_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h00) begin
            failures++;
            $display("FAIL midrst_refetch: req=%b addr=%h want 1/00",
                     bus.mem_req, bus.mem_addr);
        end
        n = 0;
        while (!halted && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL midrst_halt: halted=%b want 1", halted);
        end
    endtask

    task automatic test_random();
        int pos;
        int k;
        for (int t = 0; t < 12; t++) begin
            load_fill();
            pos = 0;
            while (pos < 36) begin
                k = int'($urandom_range(0, 9));
                if (k <= 3) begin
                    mem[pos] = {4'(1 + $urandom_range(0, 7)), 4'($urandom)};
                    pos += 1;
                end else if (k == 4) begin
                    mem[pos] = {4'h0, 4'($urandom)};
                    pos += 1;
                end else if (k <= 6) begin
                    mem[pos] = {4'h9, 4'($urandom)};
                    mem[pos+1] = {4'h0, 4'($urandom)};
                    pos += 2;
                end else if (k <= 8) begin
                    mem[pos] = {(k == 7) ? 4'hA : 4'hB, 4'($urandom)};
                    mem[pos+1] = 8'(pos + 2 + int'($urandom_range(0, 5)));
                    pos += 2;
                end else begin
                    mem[pos] = {4'(12 + $urandom_range(0, 2)), 4'($urandom)};
                    pos += 1;
                end
            end
            run_program(int'($urandom_range(0, 3)), 1'b1,
                        $sformatf("rand%0d", t));
        end
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 8'd0;
        #1;
        test_reset();
        test_program1();
        test_wait_states();
        test_jz();
        test_ldi_inc_jn();
        test_pc_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
